// File: rtl/stateful_pkg.sv
// rtl/stateful_pkg.sv - shared widths, entry layout, FSM encoding and reset tables for the stateful stage
// Purpose: common definitions for stateful_table_ctrl and stateful_port_arb.
//   entry_t       : {action, state} table entry
//   tr_addr()     : transition-table address {idx, state[2:0]}
//   S_IDLE/S_TRD/S_SWR : commit FSM encoding
//   ST_RST0, TR_RST0..2 : non-zero reset contents of the tables
package stateful_pkg;

    localparam int IDX_W            = 4;
    localparam int ST_W             = 8;
    localparam int ACT_W            = 16;
    localparam int ENT_W            = ACT_W + ST_W;
    localparam int TR_AW            = IDX_W + 3;
    localparam int ST_DEPTH         = 1 << IDX_W;
    localparam int TR_DEPTH         = 1 << TR_AW;
    localparam int STARVE_LIMIT_DEF = 16;

    typedef struct packed {
        logic [ACT_W-1:0] action;
        logic [ST_W-1:0]  state;
    } entry_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TRD  = 2'd1;
    localparam logic [1:0] S_SWR  = 2'd2;

    localparam entry_t ST_RST0 = '{action: 16'h00ff, state: 8'h00};
    localparam entry_t TR_RST0 = '{action: 16'h00ff, state: 8'h01};
    localparam entry_t TR_RST1 = '{action: 16'h00ff, state: 8'h02};
    localparam entry_t TR_RST2 = '{action: 16'h0200, state: 8'h03};

    // Only the low three state bits select a transition row; upper bits are ignored.
    function automatic logic [TR_AW-1:0] tr_addr(input logic [IDX_W-1:0] idx,
                                                 input logic [2:0]       st_lo);
        return {idx, st_lo};
    endfunction

endpackage

// File: rtl/stateful_port_arb.sv
// rtl/stateful_port_arb.sv - per-cycle table port grants and cfg starvation counter
// Purpose: decides who owns each single-port table this cycle and tracks how
// long a cfg request has waited.
// Ports:
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_lk_vld            : datapath lookup this cycle (always wins the state port)
//   i_fsm               : current commit FSM state
//   i_cfg_req/sel/addr  : control request, table select, address
//   i_cfg_ack           : ack currently being driven (request not re-served that cycle)
//   o_commit_wr         : commit write lands in the state table this cycle
//   o_cfg_grant         : cfg is served this cycle
//   o_cfg_range_err     : state-table cfg address out of range
//   o_starve_block      : cm_rdy must be low next cycle because cfg is starving
module stateful_port_arb
    import stateful_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_lk_vld,
    input  logic [1:0]       i_fsm,
    input  logic             i_cfg_req,
    input  logic             i_cfg_sel,
    input  logic [TR_AW-1:0] i_cfg_addr,
    input  logic             i_cfg_ack,
    output logic             o_commit_wr,
    output logic             o_cfg_grant,
    output logic             o_cfg_range_err,
    output logic             o_starve_block
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_cfg_pend;
    logic             w_st_free;
    logic             w_tr_free;

    // The cycle carrying an ack is not a new request even if cfg_req is still high.
    assign w_cfg_pend      = i_cfg_req & ~i_cfg_ack;
    assign o_cfg_range_err = ~i_cfg_sel & (i_cfg_addr[TR_AW-1:IDX_W] != '0);
    assign o_commit_wr     = (i_fsm == S_SWR) & ~i_lk_vld;
    assign w_st_free       = ~i_lk_vld & (i_fsm != S_SWR);
    assign w_tr_free       = (i_fsm != S_TRD);
    // Range errors touch no table, so they are answered without waiting for a port.
    assign o_cfg_grant     = w_cfg_pend &
                             (o_cfg_range_err | (i_cfg_sel ? w_tr_free : w_st_free));

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (o_cfg_grant) begin
            w_starve_nxt = '0;
        end else if (w_cfg_pend && (r_starve_cnt != LIMIT)) begin
            w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end
    end

    assign o_starve_block = (w_starve_nxt == LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

endmodule

// File: rtl/stateful_table_ctrl.sv
// rtl/stateful_table_ctrl.sv - owner of the state/action and transition tables of the stateful stage
// Purpose: fixed-latency lookups, transition commits (read transition row, then
// write state entry) and control-plane access on single-port tables.
// Ports:
//   i_clk, i_reset                          : clock, synchronous active-high reset
//   i_lk_vld, i_lk_idx                      : lookup request (never stalled)
//   o_lk_rsp_vld/_state/_action             : lookup response, one cycle later
//   i_cm_vld, i_cm_idx, i_cm_state, o_cm_rdy: commit request handshake
//   o_cm_done                               : pulse the cycle after the state write
//   i_cfg_req/_wr/_sel/_addr/_wdata         : control access, held until ack
//   o_cfg_ack, o_cfg_err, o_cfg_rdata       : control response
module stateful_table_ctrl
    import stateful_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_lk_vld,
    input  logic [IDX_W-1:0] i_lk_idx,
    output logic             o_lk_rsp_vld,
    output logic [ST_W-1:0]  o_lk_rsp_state,
    output logic [ACT_W-1:0] o_lk_rsp_action,
    input  logic             i_cm_vld,
    input  logic [IDX_W-1:0] i_cm_idx,
    input  logic [ST_W-1:0]  i_cm_state,
    output logic             o_cm_rdy,
    output logic             o_cm_done,
    input  logic             i_cfg_req,
    input  logic             i_cfg_wr,
    input  logic             i_cfg_sel,
    input  logic [TR_AW-1:0] i_cfg_addr,
    input  logic [ENT_W-1:0] i_cfg_wdata,
    output logic             o_cfg_ack,
    output logic             o_cfg_err,
    output logic [ENT_W-1:0] o_cfg_rdata
);

    entry_t           r_st_mem [ST_DEPTH];
    entry_t           r_tr_mem [TR_DEPTH];

    logic [1:0]       r_fsm;
    logic [1:0]       w_fsm_nxt;
    logic [IDX_W-1:0] r_cm_idx;
    logic [TR_AW-1:0] r_cm_tr_addr;
    entry_t           r_fetch;

    logic             r_lk_rsp_vld;
    entry_t           r_lk_rsp;
    logic             r_cm_rdy;
    logic             r_cm_done;
    logic             r_cfg_ack;
    logic             r_cfg_err;
    logic [ENT_W-1:0] r_cfg_rdata;

    logic             w_cm_acc;
    logic             w_commit_wr;
    logic             w_cfg_grant;
    logic             w_range_err;
    logic             w_starve_block;
    logic             w_unused_cm_state_hi;

    // Upper state bits do not participate in transition addressing.
    assign w_unused_cm_state_hi = ^i_cm_state[ST_W-1:3];

    assign w_cm_acc = i_cm_vld & r_cm_rdy;

    stateful_port_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_lk_vld        (i_lk_vld),
        .i_fsm           (r_fsm),
        .i_cfg_req       (i_cfg_req),
        .i_cfg_sel       (i_cfg_sel),
        .i_cfg_addr      (i_cfg_addr),
        .i_cfg_ack       (r_cfg_ack),
        .o_commit_wr     (w_commit_wr),
        .o_cfg_grant     (w_cfg_grant),
        .o_cfg_range_err (w_range_err),
        .o_starve_block  (w_starve_block)
    );

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (w_cm_acc) w_fsm_nxt = S_TRD;
            S_TRD:   w_fsm_nxt = S_SWR;
            S_SWR:   if (w_commit_wr) w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ST_DEPTH; i++) r_st_mem[i] <= '0;
            for (int i = 0; i < TR_DEPTH; i++) r_tr_mem[i] <= '0;
            r_st_mem[0]  <= ST_RST0;
            r_tr_mem[0]  <= TR_RST0;
            r_tr_mem[1]  <= TR_RST1;
            r_tr_mem[2]  <= TR_RST2;
            r_fsm        <= S_IDLE;
            r_cm_idx     <= '0;
            r_cm_tr_addr <= '0;
            r_fetch      <= '0;
            r_lk_rsp_vld <= 1'b0;
            r_lk_rsp     <= '0;
            r_cm_rdy     <= 1'b1;
            r_cm_done    <= 1'b0;
            r_cfg_ack    <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_cfg_rdata  <= '0;
        end else begin
            r_fsm    <= w_fsm_nxt;
            // Registered ready reflects the state the FSM and starve counter enter next.
            r_cm_rdy <= (w_fsm_nxt == S_IDLE) & ~w_starve_block;

            if (w_cm_acc) begin
                r_cm_idx     <= i_cm_idx;
                r_cm_tr_addr <= tr_addr(i_cm_idx, i_cm_state[2:0]);
            end
            if (r_fsm == S_TRD) begin
                r_fetch <= r_tr_mem[r_cm_tr_addr];
            end

            r_lk_rsp_vld <= i_lk_vld;
            r_lk_rsp     <= i_lk_vld ? r_st_mem[i_lk_idx] : '0;

            // Arbitration guarantees at most one of these writes per table per cycle.
            if (w_commit_wr) begin
                r_st_mem[r_cm_idx] <= r_fetch;
            end
            r_cm_done <= w_commit_wr;

            r_cfg_ack   <= w_cfg_grant;
            r_cfg_err   <= w_cfg_grant & w_range_err;
            r_cfg_rdata <= '0;
            if (w_cfg_grant && !w_range_err) begin
                if (i_cfg_sel) begin
                    if (i_cfg_wr) r_tr_mem[i_cfg_addr] <= i_cfg_wdata;
                    else          r_cfg_rdata <= r_tr_mem[i_cfg_addr];
                end else begin
                    if (i_cfg_wr) r_st_mem[i_cfg_addr[IDX_W-1:0]] <= i_cfg_wdata;
                    else          r_cfg_rdata <= r_st_mem[i_cfg_addr[IDX_W-1:0]];
                end
            end
        end
    end

    assign o_lk_rsp_vld    = r_lk_rsp_vld;
    assign o_lk_rsp_state  = r_lk_rsp.state;
    assign o_lk_rsp_action = r_lk_rsp.action;
    assign o_cm_rdy        = r_cm_rdy;
    assign o_cm_done       = r_cm_done;
    assign o_cfg_ack       = r_cfg_ack;
    assign o_cfg_err       = r_cfg_err;
    assign o_cfg_rdata     = r_cfg_rdata;

endmodule
